pool_wr_bridge: RTL
===================

Name: pool_wr_bridge

Overview:
Write-side counterpart of the pooling layer's bus read bridge. Accepts one pooled pixel vector (channel_size channels x 32 bits) from the pool/conv layer side and stores it to memory as repeat_time fixed-length write bursts of width-bit beats. Each burst uses an address / data / response handshake on the shared bus. Sits between the pooling layer output and the bus interconnect.

Parameters:
channel_size, 64, channels per pixel vector; the vector is channel_size*32 bits
repeat_time, 4, write bursts needed per vector
width, 32, bus data width in bits
burst_len, 16, beats per burst; channel_size*32 must equal repeat_time*burst_len*width (elaboration error otherwise)
addr_step, 28'h000_0010, address increment between consecutive bursts
wr_id, 4'h2, transaction id driven on awuser_id; the B response must carry the same id

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
wr_addr  input  28  base address of the vector, sampled on accept
pool_out  input  channel_size*32  pixel vector; channel 0 sits in the MSBs
out_valid  input  1  pool_out/wr_addr valid
out_ready  output  1  bridge idle; high only in IDLE
done  output  1  one-cycle pulse after the final B response
err  output  1  sticky: some bresp != 0 in the current vector; cleared on accept
awvalid  output  1  write address valid
awready  input  1  write address ready
awaddr  output  28  burst address
awlen  output  4  burst_len-1
awuser_id  output  4  wr_id while awvalid, else 0
awuser_ap  output  1  high while awvalid
wvalid  output  1  write data valid
wready  input  1  write data ready
wdata  output  width  beat data
wlast  output  1  final beat of the burst
bvalid  input  1  response valid
bready  output  1  response ready
bid  input  4  response id
bresp  input  2  response code; 0 = OK

Behaviour:
- Reset: all outputs 0 except out_ready = 1; FSM = IDLE; counters 0. Reset mid-operation aborts immediately and drops the buffered vector; the bus may hold a partial burst.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- IDLE:
  - out_ready = 1.
  - On out_valid: latch pool_out into the shift buffer and wr_addr into the base register; clear err, burst_cnt and beat_cnt; go to AW.
  - awvalid rises on the cycle after accept.
- AW:
  - awvalid = 1, awaddr = base + burst_cnt*addr_step (mod 2^28), awlen = burst_len-1, awuser_id = wr_id, awuser_ap = 1.
  - Hold all of these stable until awready; go to W on awvalid && awready.
- W:
  - wvalid = 1; wdata = top width bits of the shift buffer, so channel 0 / MSB word goes first (mirror of the read bridge's LSB shift-in).
  - On wvalid && wready: shift the buffer left by width and increment beat_cnt.
  - wlast = (beat_cnt == burst_len-1).
  - On the wlast handshake: beat_cnt <- 0, go to B.
  - wdata and wlast hold stable while wready is low.
  - Minimum one beat per cycle.
- B:
  - bready = 1.
  - On bvalid && bid == wr_id: if bresp != 0, set err. Then:
    - if burst_cnt == repeat_time-1, pulse done and go to IDLE;
    - otherwise burst_cnt++ and go to AW.
  - bvalid with a mismatched bid is accepted and ignored; stay in B.
- A new vector is never accepted before done; out_ready is low from accept through the done cycle.
- Counter widths: beat_cnt is $clog2(burst_len); burst_cnt is $clog2(repeat_time)+1.
- Zero-wait timing per burst: AW 1 cycle, W burst_len cycles, B 1 cycle.
- Accept-to-done with no backpressure: repeat_time*(burst_len+2) cycles (72 at defaults).

Decomposition:
- Shared package pool_bus_pkg holds:
  - FSM state typedef (IDLE, AW, W, B);
  - bus ids (read id 4'h1, arbitration id 4'h3, write id 4'h2);
  - BRESP_OK = 2'b00;
  - default addr_step.
- One natural sub-module: pool_wr_shifter, the parallel-load / left-shift buffer that presents the top width bits.

Test Plan:
- Single vector, base 28'h000_1000, channel k = 32'hA000_0000+k, all ready/valid immediate:
  - awaddr sequence 0x1000, 0x1010, 0x1020, 0x1030; awlen = 15;
  - 64 beats with wdata = A000_0000 .. A000_003F in order; wlast on beats 15/31/47/63;
  - done exactly 72 cycles after accept; err = 0.
- Random wready stalls (50%) and awready delayed by 5 cycles:
  - awaddr, wdata and wlast stay stable while stalled;
  - data order unchanged; no dropped or duplicated beats.
- bvalid with bid = 4'h1 before the correct bid = 4'h2:
  - first response ignored; burst_cnt advances only on the matching response.
- bresp = 2'b10 on burst 2:
  - err set and held through done;
  - next accept clears err.
- Base 28'hFFF_FFE0: burst addresses 0xFFFFFE0, 0xFFFFFF0, 0x0000000, 0x0000010 (wrap).
- rst_n asserted during beat 20:
  - all outputs go to reset values asynchronously; out_ready = 1;
  - a new vector after release completes normally from burst 0.

Source files
------------

// File: rtl/pool_bus_pkg.sv
// pool_bus_pkg: shared FSM states, bus ids and defaults for the pooling bus bridges
package pool_bus_pkg;
    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
    localparam logic [3:0] RD_ID = 4'h1;
    localparam logic [3:0] ARB_ID = 4'h3;
    localparam logic [3:0] WR_ID = 4'h2;
    localparam logic [1:0] BRESP_OK = 2'b00;
    localparam logic [27:0] ADDR_STEP = 28'h000_0010;
endpackage

// File: rtl/pool_wr_bridge_if.sv
// pool_wr_bridge_if: write address / data / response bus between bridge and interconnect
interface pool_wr_bridge_if #(parameter int width = 32);
    logic awvalid;
    logic awready;
    logic [27:0] awaddr;
    logic [3:0] awlen;
    logic [3:0] awuser_id;
    logic awuser_ap;
    logic wvalid;
    logic wready;
    logic [width-1:0] wdata;
    logic wlast;
    logic bvalid;
    logic bready;
    logic [3:0] bid;
    logic [1:0] bresp;
    modport master (
        output awvalid, awaddr, awlen, awuser_id, awuser_ap, wvalid, wdata, wlast, bready,
        input awready, wready, bvalid, bid, bresp
    );
    modport slave (
        input awvalid, awaddr, awlen, awuser_id, awuser_ap, wvalid, wdata, wlast, bready,
        output awready, wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/pool_wr_shifter.sv
// pool_wr_shifter: parallel-load buffer that shifts left one beat at a time, exposing its top bits
module pool_wr_shifter #(
    parameter int total = 2048,
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [total-1:0] din,
    output logic [width-1:0] dout
);
    logic [total-1:0] sr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else if (load) sr_q <= din;
        else if (shift) sr_q <= sr_q << width;
    end
    assign dout = sr_q[total-1 -: width];
endmodule

// File: rtl/pool_wr_bridge.sv
// pool_wr_bridge: stores one pooled pixel vector to memory as repeat_time fixed-length write bursts
module pool_wr_bridge
    import pool_bus_pkg::*;
#(
    parameter int channel_size = 64,
    parameter int repeat_time = 4,
    parameter int width = 32,
    parameter int burst_len = 16,
    parameter logic [27:0] addr_step = ADDR_STEP,
    parameter logic [3:0] wr_id = WR_ID
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [27:0]               wr_addr,
    input  logic [channel_size*32-1:0] pool_out,
    input  logic                      out_valid,
    output logic                      out_ready,
    output logic                      done,
    output logic                      err,
    pool_wr_bridge_if.master          bus
);
    localparam int BEAT_W = $clog2(burst_len);
    localparam int BURST_W = $clog2(repeat_time) + 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(burst_len - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(repeat_time - 1);

    if (channel_size * 32 != repeat_time * burst_len * width) begin : g_bad_cfg
        $error("pool_wr_bridge: vector size must equal repeat_time*burst_len*width");
    end

    state_t state_q, state_d;
    logic [27:0] base_q;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic done_q, err_q;
    logic accept, w_hs, b_hit, last_beat, last_burst;

    // out_ready stays low through the done cycle so a new vector waits for completion
    assign accept = state_q == IDLE && !done_q && out_valid;
    assign w_hs = state_q == W && bus.wready;
    assign b_hit = state_q == B && bus.bvalid && bus.bid == wr_id;
    assign last_beat = beat_cnt == BEAT_LAST;
    assign last_burst = burst_cnt == BURST_LAST;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? AW : IDLE;
            AW:      state_d = bus.awready ? W : AW;
            W:       state_d = (bus.wready && last_beat) ? B : W;
            B:       state_d = b_hit ? (last_burst ? IDLE : AW) : B;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q <= '0;
            beat_cnt <= '0;
            burst_cnt <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q <= b_hit && last_burst;
            if (accept) begin
                base_q <= wr_addr;
                beat_cnt <= '0;
                burst_cnt <= '0;
                err_q <= 1'b0;
            end
            if (w_hs) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (b_hit) begin
                err_q <= err_q | (bus.bresp != BRESP_OK);
                if (!last_burst) burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    pool_wr_shifter #(.total(channel_size * 32), .width(width)) u_shift (
        .clk(clk),
        .rst_n(rst_n),
        .load(accept),
        .shift(w_hs),
        .din(pool_out),
        .dout(bus.wdata)
    );

    assign out_ready = state_q == IDLE && !done_q;
    assign done = done_q;
    assign err = err_q;
    assign bus.awvalid = state_q == AW;
    assign bus.awaddr = bus.awvalid ? base_q + 28'(burst_cnt) * addr_step : '0;
    assign bus.awlen = bus.awvalid ? 4'(burst_len - 1) : '0;
    assign bus.awuser_id = bus.awvalid ? wr_id : '0;
    assign bus.awuser_ap = bus.awvalid;
    assign bus.wvalid = state_q == W;
    assign bus.wlast = bus.wvalid && last_beat;
    assign bus.bready = state_q == B;
endmodule
